// File: rtl/dtree_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dtree_pkg
// Description : Shared types and constants for the decision-tree sequencer.
//               Node word layout (MSB..LSB):
//                 {child_flags[2], one_pos[FEATURES],
//                  coeff[FEATURES-2] .. coeff[0], bias[BIAS_BIT_DEPTH]}
//               coeff[0] sits directly above the bias field.
// Revision    : 1.0 - initial release
// ============================================================================
package dtree_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EVAL  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // child_flags encodings: bit1 = left child exists, bit0 = right child exists
    localparam logic [1:0] C_FLAGS_NONE  = 2'b00;
    localparam logic [1:0] C_FLAGS_LEFT  = 2'b10;
    localparam logic [1:0] C_FLAGS_RIGHT = 2'b01;
    localparam logic [1:0] C_FLAGS_BOTH  = 2'b11;

    function automatic int f_word_w(input int features, input int coeff_w, input int bias_w);
        return 2 + features + (features - 1) * coeff_w + bias_w;
    endfunction

    function automatic int f_bias_lsb();
        return 0;
    endfunction

    function automatic int f_coeff_lsb(input int idx, input int coeff_w, input int bias_w);
        return bias_w + idx * coeff_w;
    endfunction

    function automatic int f_one_lsb(input int features, input int coeff_w, input int bias_w);
        return bias_w + (features - 1) * coeff_w;
    endfunction

    function automatic int f_flags_lsb(input int features, input int coeff_w, input int bias_w);
        return f_one_lsb(features, coeff_w, bias_w) + features;
    endfunction

    // A decision may descend only into a child the node actually has.
    function automatic logic f_child_valid(input logic [1:0] flags, input logic dir);
        logic v;
        v = 1'b0;
        case (flags)
            C_FLAGS_LEFT:  v = !dir;
            C_FLAGS_RIGHT: v = dir;
            C_FLAGS_BOTH:  v = 1'b1;
            default:       v = 1'b0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dtree_sequencer_node_memory.sv
`default_nettype none
// ============================================================================
// Module      : node_memory
// Description : Single-clock node RAM, one synchronous read port and one
//               write port. A read and write to the same address in the same
//               cycle returns the previous contents. Read data holds while
//               i_re is low. No reset: contents survive sequencer reset.
// Ports       : clk; i_we/i_waddr/i_wdata write port;
//               i_re/i_raddr read request; o_rdata registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
module node_memory #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 23,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Addresses past the last node are silently dropped.
    always_ff @(posedge clk) begin
        if (i_we && ({1'b0, i_waddr} < (AW+1)'(DEPTH))) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dtree_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dtree_sequencer
// Description : Walks a per-channel oblique decision tree held in node RAM.
//               Per node: FETCH (RAM read), FEATURES EVAL slots driving the
//               MAC datapath, WAIT for the sign decision. Emits the path as a
//               left-aligned label through a valid/ready handshake.
// Ports       : clk, reset (sync, active low)
//               in_valid/in_channel/ready     spike input handshake
//               dir_valid/child_direction     datapath decision
//               node_valid/load_bias/mult/is_one/is_zero/coeff/bias  MAC ctrl
//               out_valid/out_ready/out_label/out_level/out_channel  result
//               cfg_we/cfg_addr/cfg_data      run-time node RAM writes
// Revision    : 1.0 - initial release
// ============================================================================
module dtree_sequencer
    import dtree_pkg::*;
#(
    parameter int FEATURES        = 3,
    parameter int COEFF_BIT_DEPTH = 4,
    parameter int BIAS_BIT_DEPTH  = 10,
    parameter int TREE_DEPTH      = 3,
    parameter int CHANNEL_COUNT   = 2,
    localparam int NODES  = (2 ** TREE_DEPTH) - 1,
    localparam int CHW    = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
    localparam int WORD_W = f_word_w(FEATURES, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH),
    localparam int AW     = (NODES * CHANNEL_COUNT > 1) ? $clog2(NODES * CHANNEL_COUNT) : 1,
    localparam int LW     = $clog2(TREE_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [CHW-1:0]             in_channel,
    output logic                       ready,
    input  logic                       dir_valid,
    input  logic                       child_direction,
    output logic                       node_valid,
    output logic                       load_bias,
    output logic                       mult,
    output logic                       is_one,
    output logic                       is_zero,
    output logic [COEFF_BIT_DEPTH-1:0] coeff,
    output logic [BIAS_BIT_DEPTH-1:0]  bias,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TREE_DEPTH-1:0]      out_label,
    output logic [LW-1:0]              out_level,
    output logic [CHW-1:0]             out_channel,
    input  logic                       cfg_we,
    input  logic [AW-1:0]              cfg_addr,
    input  logic [WORD_W-1:0]          cfg_data
);

    localparam int NW   = $clog2(NODES + 1);
    localparam int KW   = $clog2(FEATURES);
    localparam int CSEL = 2 ** KW;

    state_t                r_state;
    state_t                w_state_next;
    logic [CHW-1:0]        r_channel;
    logic [NW-1:0]         r_node;
    logic [LW-1:0]         r_depth;
    logic [TREE_DEPTH-1:0] r_path;
    logic [KW-1:0]         r_k;
    logic [KW-1:0]         r_ci;
    logic [TREE_DEPTH-1:0] r_label;
    logic [LW-1:0]         r_level;

    logic [WORD_W-1:0]          w_rdata;
    logic [AW-1:0]              w_rd_addr;
    logic [1:0]                 w_flags;
    logic [FEATURES-1:0]        w_one_pos;
    logic [BIAS_BIT_DEPTH-1:0]  w_bias;
    logic [COEFF_BIT_DEPTH-1:0] w_coeffs [CSEL];
    logic [COEFF_BIT_DEPTH-1:0] w_coeff;
    logic [KW-1:0]              w_one_idx;
    logic                       w_is_one;
    logic                       w_descend;
    logic [TREE_DEPTH-1:0]      w_path_next;
    logic [LW-1:0]              w_shift;
    logic [TREE_DEPTH-1:0]      w_label;

    // ------------------------------------------------------------------
    // Node RAM
    // ------------------------------------------------------------------
    assign w_rd_addr = AW'(r_channel) * AW'(NODES) + AW'(r_node);

    node_memory #(
        .DEPTH (NODES * CHANNEL_COUNT),
        .WIDTH (WORD_W),
        .AW    (AW)
    ) u_node_memory (
        .clk     (clk),
        .i_we    (cfg_we),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_data),
        .i_re    (r_state == ST_FETCH),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // Node word fields
    // ------------------------------------------------------------------
    assign w_flags   = w_rdata[f_flags_lsb(FEATURES, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH) +: 2];
    assign w_one_pos = w_rdata[f_one_lsb(FEATURES, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH) +: FEATURES];
    assign w_bias    = w_rdata[f_bias_lsb() +: BIAS_BIT_DEPTH];

    // Coefficient table padded to a power of two; the pad entries read as
    // zero, so a node with no unit-weight feature skips its last slot.
    for (genvar gi = 0; gi < CSEL; gi++) begin : g_coeff
        if (gi < FEATURES - 1) begin : g_stored
            assign w_coeffs[gi] =
                w_rdata[f_coeff_lsb(gi, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH) +: COEFF_BIT_DEPTH];
        end else begin : g_pad
            assign w_coeffs[gi] = '0;
        end
    end

    assign w_coeff   = w_coeffs[r_ci];
    assign w_one_idx = KW'(FEATURES - 1) - r_k;
    assign w_is_one  = w_one_pos[w_one_idx];

    // ------------------------------------------------------------------
    // Decision bookkeeping
    // ------------------------------------------------------------------
    assign w_descend   = f_child_valid(w_flags, child_direction)
                         && (r_depth < LW'(TREE_DEPTH - 1));
    assign w_path_next = TREE_DEPTH'({r_path, child_direction});
    // Left-align the r_depth+1 path bits taken so far.
    assign w_shift     = LW'(TREE_DEPTH - 1) - r_depth;
    assign w_label     = w_path_next << w_shift;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_channel <= '0;
            r_node    <= '0;
            r_depth   <= '0;
            r_path    <= '0;
            r_k       <= '0;
            r_ci      <= '0;
            r_label   <= '0;
            r_level   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_channel <= in_channel;
                        r_node    <= '0;
                        r_depth   <= '0;
                        r_path    <= '0;
                    end
                end
                ST_FETCH: begin
                    r_k  <= '0;
                    r_ci <= '0;
                end
                ST_EVAL: begin
                    r_k <= r_k + KW'(1);
                    if (!w_is_one) begin
                        r_ci <= r_ci + KW'(1);
                    end
                end
                ST_WAIT: begin
                    if (dir_valid) begin
                        if (w_descend) begin
                            r_node  <= (r_node << 1) + NW'(1) + NW'(child_direction);
                            r_path  <= w_path_next;
                            r_depth <= r_depth + LW'(1);
                        end else begin
                            r_label <= w_label;
                            r_level <= r_depth + LW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        node_valid   = 1'b0;
        load_bias    = 1'b0;
        mult         = 1'b0;
        is_one       = 1'b0;
        is_zero      = 1'b0;
        coeff        = '0;
        bias         = '0;
        out_valid    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Gated by reset so the block never advertises readiness
                // while it is being held in reset.
                ready = reset;
                if (in_valid) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_next = ST_EVAL;
            end
            ST_EVAL: begin
                node_valid = 1'b1;
                load_bias  = (r_k == '0);
                is_one     = w_is_one;
                is_zero    = !w_is_one && (w_coeff == '0);
                mult       = !w_is_one && (w_coeff != '0);
                coeff      = w_coeff;
                bias       = w_bias;
                if (r_k == KW'(FEATURES - 1)) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dir_valid) begin
                    w_state_next = w_descend ? ST_FETCH : ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign out_label   = r_label;
    assign out_level   = r_level;
    assign out_channel = r_channel;

endmodule
`default_nettype wire

// File: tb/tb_dtree_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtree_sequencer
// Description : Self-checking bench for dtree_sequencer. A reference model
//               holds a copy of node RAM and derives, from the node-word
//               rules, the expected slot controls, node sequence and label.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtree_sequencer;

    localparam int FEATURES        = 3;
    localparam int COEFF_BIT_DEPTH = 4;
    localparam int BIAS_BIT_DEPTH  = 10;
    localparam int TREE_DEPTH      = 3;
    localparam int CHANNEL_COUNT   = 2;
    localparam int NODES           = 7;
    localparam int CHW             = 1;
    localparam int WORD_W          = 2 + FEATURES + (FEATURES - 1) * COEFF_BIT_DEPTH + BIAS_BIT_DEPTH;
    localparam int AW              = 4;
    localparam int LW              = 2;

    logic                       clk;
    logic                       reset;
    logic                       in_valid;
    logic [CHW-1:0]             in_channel;
    logic                       ready;
    logic                       dir_valid;
    logic                       child_direction;
    logic                       node_valid;
    logic                       load_bias;
    logic                       mult;
    logic                       is_one;
    logic                       is_zero;
    logic [COEFF_BIT_DEPTH-1:0] coeff;
    logic [BIAS_BIT_DEPTH-1:0]  bias;
    logic                       out_valid;
    logic                       out_ready;
    logic [TREE_DEPTH-1:0]      out_label;
    logic [LW-1:0]              out_level;
    logic [CHW-1:0]             out_channel;
    logic                       cfg_we;
    logic [AW-1:0]              cfg_addr;
    logic [WORD_W-1:0]          cfg_data;

    dtree_sequencer #(
        .FEATURES        (FEATURES),
        .COEFF_BIT_DEPTH (COEFF_BIT_DEPTH),
        .BIAS_BIT_DEPTH  (BIAS_BIT_DEPTH),
        .TREE_DEPTH      (TREE_DEPTH),
        .CHANNEL_COUNT   (CHANNEL_COUNT)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_channel      (in_channel),
        .ready           (ready),
        .dir_valid       (dir_valid),
        .child_direction (child_direction),
        .node_valid      (node_valid),
        .load_bias       (load_bias),
        .mult            (mult),
        .is_one          (is_one),
        .is_zero         (is_zero),
        .coeff           (coeff),
        .bias            (bias),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_label       (out_label),
        .out_level       (out_level),
        .out_channel     (out_channel),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference copy of node RAM, updated whenever the bench drives a write.
    logic [WORD_W-1:0] m_mem [NODES*CHANNEL_COUNT];
    int                visited[$];

    // Optional writes injected during a walk.
    bit                mid_en;
    int                mid_addr;
    logic [WORD_W-1:0] mid_data;
    bit                col_en;
    int                col_addr;
    logic [WORD_W-1:0] col_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WORD_W-1:0] mk_word(input int flags, input int one_pos,
                                                  input int c0, input int c1, input int b);
        longint w;
        w = (longint'(flags & 3) << (WORD_W - 2))
          | (longint'(one_pos & 7) << (BIAS_BIT_DEPTH + 2 * COEFF_BIT_DEPTH))
          | (longint'(c1 & 15) << (BIAS_BIT_DEPTH + COEFF_BIT_DEPTH))
          | (longint'(c0 & 15) << BIAS_BIT_DEPTH)
          | longint'(b & 1023);
        return WORD_W'(w);
    endfunction

    function automatic logic [WORD_W-1:0] rand_word();
        int one;
        int c0;
        int c1;
        one = ($urandom_range(0, 3) == 0) ? 0 : (1 << $urandom_range(0, FEATURES - 1));
        c0  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 15));
        c1  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 15));
        return mk_word(int'($urandom_range(0, 3)), one, c0, c1, int'($urandom_range(0, 1023)));
    endfunction

    task automatic cfg_write(input int addr, input logic [WORD_W-1:0] data);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = data;
        m_mem[addr] = data;
        tick();
        cfg_we = 1'b0;
    endtask

    // One complete spike: accept, walk, label handshake. Expected slot
    // controls come from the node word snapshot taken at that node's FETCH.
    task automatic run_spike(input int ch, input bit use_fixed, input int fixed_dirs,
                             input bit early, input int wait_max, input int hold);
        int                node;
        int                depth;
        int                path;
        int                dir;
        int                flags;
        int                one_pos;
        int                ci;
        int                c;
        int                waitc;
        bit                cv;
        bit                fin;
        bit                one;
        logic [WORD_W-1:0] word;
        longint            wl;

        node  = 0;
        depth = 0;
        path  = 0;
        fin   = 1'b0;
        visited.delete();

        check("idle_ready", ready, 1);
        in_valid   = 1'b1;
        in_channel = CHW'(ch);
        tick();
        in_valid   = 1'b0;

        while (!fin) begin
            check("fetch_node_valid", node_valid, 0);
            check("fetch_ready", ready, 0);
            word = m_mem[ch * NODES + node];
            visited.push_back(node);
            if (col_en && depth == 1) begin
                cfg_we   = 1'b1;
                cfg_addr = AW'(col_addr);
                cfg_data = col_data;
                m_mem[col_addr] = col_data;
                col_en = 1'b0;
            end
            tick();
            cfg_we = 1'b0;

            wl      = longint'(word);
            one_pos = int'((wl >> (BIAS_BIT_DEPTH + 2 * COEFF_BIT_DEPTH)) & 7);
            flags   = int'((wl >> (WORD_W - 2)) & 3);
            ci      = 0;
            for (int k = 0; k < FEATURES; k++) begin
                one = ((one_pos >> (FEATURES - 1 - k)) & 1) != 0;
                c   = 0;
                if (!one) begin
                    if (ci < FEATURES - 1) begin
                        c = int'((wl >> (BIAS_BIT_DEPTH + ci * COEFF_BIT_DEPTH)) & 15);
                    end
                    ci++;
                end
                check("slot_node_valid", node_valid, 1);
                check("slot_load_bias", load_bias, (k == 0) ? 1 : 0);
                check("slot_is_one", is_one, one ? 1 : 0);
                check("slot_is_zero", is_zero, (!one && c == 0) ? 1 : 0);
                check("slot_mult", mult, (!one && c != 0) ? 1 : 0);
                if (!one) begin
                    check("slot_coeff", coeff, c);
                end
                check("slot_bias", bias, wl & 1023);
                if (mid_en && depth == 0 && k == 0) begin
                    cfg_we   = 1'b1;
                    cfg_addr = AW'(mid_addr);
                    cfg_data = mid_data;
                    m_mem[mid_addr] = mid_data;
                    mid_en = 1'b0;
                end
                if (early && k == 1) begin
                    dir_valid       = 1'b1;
                    child_direction = 1'($urandom_range(0, 1));
                end
                tick();
                cfg_we    = 1'b0;
                dir_valid = 1'b0;
            end

            waitc = int'($urandom_range(0, wait_max));
            for (int w = 0; w < waitc; w++) begin
                check("wait_node_valid", node_valid, 0);
                check("wait_out_valid", out_valid, 0);
                tick();
            end
            check("wait_node_valid", node_valid, 0);

            dir = use_fixed ? ((fixed_dirs >> (TREE_DEPTH - 1 - depth)) & 1)
                            : int'($urandom_range(0, 1));
            dir_valid       = 1'b1;
            child_direction = 1'(dir);
            tick();
            dir_valid = 1'b0;

            cv   = (flags == 3) || (flags == 2 && dir == 0) || (flags == 1 && dir == 1);
            path = path * 2 + dir;
            if (cv && depth < TREE_DEPTH - 1) begin
                node = 2 * node + 1 + dir;
            end else begin
                fin = 1'b1;
            end
            depth++;
        end

        // Label held while the consumer stalls; spurious spikes are ignored.
        for (int h = 0; h <= hold; h++) begin
            check("done_out_valid", out_valid, 1);
            check("done_label", out_label, path << (TREE_DEPTH - depth));
            check("done_level", out_level, depth);
            check("done_channel", out_channel, ch);
            check("done_ready", ready, 0);
            if (h < hold) begin
                in_valid   = 1'b1;
                in_channel = CHW'(1 - ch);
                tick();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_ready", ready, 1);
    endtask

    initial begin
        reset           = 1'b0;
        in_valid        = 1'b0;
        in_channel      = '0;
        dir_valid       = 1'b0;
        child_direction = 1'b0;
        out_ready       = 1'b0;
        cfg_we          = 1'b0;
        cfg_addr        = '0;
        cfg_data        = '0;
        mid_en          = 1'b0;
        col_en          = 1'b0;
        mid_addr        = 0;
        col_addr        = 0;
        mid_data        = '0;
        col_data        = '0;

        repeat (3) tick();
        check("rst_ready", ready, 0);
        check("rst_out_valid", out_valid, 0);
        reset = 1'b1;
        tick();
        check("post_rst_ready", ready, 1);

        // Test 2 configuration: every ch0 node shares the pattern, distinct bias.
        for (int n = 0; n < NODES; n++) begin
            cfg_write(n, mk_word(3, 3'b100, 3, 0, 5 + n));
        end
        cfg_write(NODES + 0, mk_word(2, 3'b001, 7, 0, 77));
        for (int n = 1; n < NODES; n++) begin
            cfg_write(NODES + n, rand_word());
        end

        // Test 1: reset mid-EVAL abandons the spike.
        in_valid   = 1'b1;
        in_channel = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre_rst_node_valid", node_valid, 1);
        reset = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tick();
            check("rst_ready", ready, 0);
            check("rst_zero_ctrl", {node_valid, load_bias, mult, is_one, is_zero}, 0);
            check("rst_zero_coeff", coeff, 0);
            check("rst_zero_bias", bias, 0);
            check("rst_zero_out", {out_valid, out_label, out_level, out_channel}, 0);
        end
        reset = 1'b1;
        tick();
        check("release_ready", ready, 1);
        for (int r = 0; r < 3; r++) begin
            check("release_no_label", out_valid, 0);
            tick();
        end

        // Test 2: dirs 1,0,1 on ch0.
        run_spike(0, 1'b1, 3'b101, 1'b0, 0, 0);
        check("t2_visits", visited.size(), 3);
        if (visited.size() == 3) begin
            check("t2_node1", visited[1], 2);
            check("t2_node2", visited[2], 5);
        end

        // Test 3: ch1 root only has a left child, dir=1 ends the walk.
        run_spike(1, 1'b1, 3'b100, 1'b0, 0, 0);
        check("t3_visits", visited.size(), 1);

        // Test 4: consumer stalls 10 cycles.
        run_spike(0, 1'b1, 3'b010, 1'b0, 1, 10);

        // Test 5: early dir pulse during EVAL, decisions delayed 4 cycles.
        run_spike(0, 1'b1, 3'b110, 1'b1, 4, 1);

        // Test 6: rewrite node 2 during node-0 EVAL, then collide at its FETCH.
        mid_en   = 1'b1;
        mid_addr = 2;
        mid_data = mk_word(3, 3'b010, 9, 4, 300);
        col_en   = 1'b1;
        col_addr = 2;
        col_data = mk_word(3, 3'b001, 0, 0, 600);
        run_spike(0, 1'b1, 3'b101, 1'b0, 0, 0);
        check("t6_node1", (visited.size() > 1) ? visited[1] : -1, 2);
        // The collided word is now resident and must be used next time.
        run_spike(0, 1'b1, 3'b100, 1'b0, 0, 0);

        // Randomised walks over randomised trees with occasional live writes.
        for (int a = 0; a < NODES * CHANNEL_COUNT; a++) begin
            cfg_write(a, rand_word());
        end
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                mid_en   = 1'b1;
                mid_addr = int'($urandom_range(0, NODES * CHANNEL_COUNT - 1));
                mid_data = rand_word();
            end
            run_spike(int'($urandom_range(0, CHANNEL_COUNT - 1)), 1'b0, 0,
                      1'($urandom_range(0, 1)), 3, int'($urandom_range(0, 3)));
            mid_en = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dtree_sequencer.md
Name: dtree_sequencer

Overview:
Parametrised successor to the single-channel, fixed-depth tree controller. It walks an oblique decision tree of configurable depth, stored per channel in an on-chip node memory that can be written at run time. For each spike it drives the shared MAC datapath one feature per cycle and waits for the datapath's sign decision. It returns a cluster label through a valid/ready output handshake and sits between the spike detector and the MAC/comparator datapath.

Parameters:
FEATURES, 3, features per spike vector (>=2)
COEFF_BIT_DEPTH, 4, stored coefficient width
BIAS_BIT_DEPTH, 10, node bias width
TREE_DEPTH, 3, maximum decisions per spike (>=1); nodes per channel NODES = 2^TREE_DEPTH-1
CHANNEL_COUNT, 2, independent trees (>=1); CHW = max(1,clog2(CHANNEL_COUNT))
WORD_W, derived = 2+FEATURES+(FEATURES-1)*COEFF_BIT_DEPTH+BIAS_BIT_DEPTH

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  spike available
in_channel  in  CHW  channel of that spike
ready  out  1  sequencer idle, accepts a spike
dir_valid  in  1  datapath decision valid
child_direction  in  1  datapath decision: 0 = left, 1 = right
node_valid  out  1  feature slot active
load_bias  out  1  datapath loads bias (first feature slot)
mult  out  1  multiply the feature by coeff
is_one  out  1  feature passes with unit weight
is_zero  out  1  feature skipped
coeff  out  COEFF_BIT_DEPTH  current coefficient
bias  out  BIAS_BIT_DEPTH  current node bias
out_valid  out  1  label valid
out_ready  in  1  consumer accepts label
out_label  out  TREE_DEPTH  path bits, MSB = first decision
out_level  out  clog2(TREE_DEPTH+1)  number of decisions taken
out_channel  out  CHW  channel of the label
cfg_we  in  1  node memory write strobe
cfg_addr  in  clog2(NODES*CHANNEL_COUNT)  write address = ch*NODES+node
cfg_data  in  WORD_W  node word: {child_flags[2], one_pos[FEATURES], coeff[FEATURES-1], bias}

Behaviour:
- Reset (reset==0 at posedge): state IDLE; node, depth and path cleared; all outputs 0. ready is 0 while reset is low. Memory contents are preserved. Reset mid-walk abandons the spike, and no label is emitted.
- IDLE: ready=1. On in_valid&ready: latch in_channel, node=0, depth=0, path=0, go to FETCH.
- FETCH: one cycle. The memory read address is ch*NODES+node (synchronous read). Go to EVAL with k=0 and coeff_index=0.
- EVAL: FEATURES cycles, k=0..FEATURES-1, with node_valid=1.
  - load_bias=(k==0). is_one=one_pos[FEATURES-1-k].
  - coeff=coeff[coeff_index]. is_zero = !is_one & coeff==0. mult = !is_one & coeff!=0.
  - Exactly one of is_one, is_zero and mult is high in each slot.
  - coeff_index increments only when !is_one. At most one one_pos bit may be set; more than one is a configuration error and the behaviour is undefined.
  - After k=FEATURES-1, go to WAIT.
- WAIT: node_valid=0; wait for dir_valid, with no timeout. dir_valid in any other state is ignored. On dir_valid:
  - child_valid: flags 00 gives 0; 10 gives dir==0; 01 gives dir==1; 11 gives 1.
  - If child_valid and depth<TREE_DEPTH-1: node=2*node+1+dir, path={path,dir}, depth+1, go to FETCH.
  - Otherwise the walk ends: out_label = {path,dir} left-aligned, zero-padded LSBs; out_level=depth+1; go to DONE.
- DONE: out_valid=1. Label, level and channel are held stable until out_ready. On out_ready go to IDLE, with no bubble requirement. ready stays 0 in DONE.
- Latency per decision = 1+FEATURES+(datapath latency) cycles. A full-depth walk with 1-cycle dir_valid takes TREE_DEPTH*(FEATURES+2) cycles.
- cfg writes are accepted in any state. A write to the address being read in the same cycle returns the old data. A write during a walk takes effect at the next FETCH of that node.
- Node index arithmetic uses clog2(NODES+1) bits; overflow is impossible by the depth guard.

Decomposition:
- Shared package dtree_pkg holds:
  - field offset and width constants for child_flags, one_pos, coeff(i) and bias as functions of the parameters, replacing textual macros;
  - the state enum (IDLE, FETCH, EVAL, WAIT, DONE);
  - the child_flags encodings.
- Sub-module node_memory: single-clock RAM, NODES*CHANNEL_COUNT x WORD_W, one synchronous read port and one write port, read-old-on-collision.

Test Plan:
1. Reset held low 3 cycles mid-EVAL -> all outputs 0, ready 0; after release ready=1 next cycle, no out_valid.
2. ch0 node0 word flags=11, one_pos=100, coeffs {3,0}, bias=5; dirs 1,0,1 -> slots per node: is_one, mult coeff=3, is_zero; nodes visited 0,2,5; out_label=101, out_level=3, out_channel=0.
3. ch1 node0 flags=10, dir=1 -> leaf at first decision: out_label=100, out_level=1, out_channel=1.
4. out_ready held low 10 cycles -> out_valid and label stable, ready=0, in_valid ignored; spike accepted only after handshake.
5. dir_valid pulsed during EVAL then delayed 4 cycles in WAIT -> early pulse ignored, walk resumes on the WAIT pulse, label correct.
6. cfg_we to ch0 node2 while walking node0 -> new word used at node2 FETCH; same-cycle collision returns old word.
